reg_file_wb: RTL and testbench
==============================

// Module: reg_file_wb
// PURPOSE
//  - Architectural register file of the single-cycle RV32I core: 32 x 32-bit GPRs.
//  - Write-back destination: consumes rd_din from the PC-to-reg / memory-to-reg write-back
//    mux chain and feeds rs1/rs2 operands to the ALU source mux.
//  - Also owns the ECALL halt state machine (x17 == HALT_CODE) and a retired-instruction counter.
// PARAMETERS
//  - STACK_INIT  32'h0000_2FFF  reset value of x2 (sp)
//  - HALT_CODE   32'd10         x17 value that makes ECALL halt the core
//  - CNT_W       32             width of retire_count
// PORTS
//  - clk           in   1      core clock; all state updates on posedge
//  - reset         in   1      synchronous, active-high
//  - rs1           in   5      read port 1 address
//  - rs2           in   5      read port 2 address
//  - rd            in   5      write address
//  - rd_din        in   32     write data from the write-back mux
//  - write_enable  in   1      register write strobe from control
//  - is_ecall      in   1      current instruction is ECALL
//  - rs1_dout      out  32     read data port 1
//  - rs2_dout      out  32     read data port 2
//  - is_halted     out  1      core halted; PC update and memory writes gated by top level
//  - retire_count  out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  - Reset (reset=1 at posedge): x2 <= STACK_INIT; all other regs <= 0; state <= RUN;
//    retire_count <= 0. is_halted=0 out of reset.
//  - Reads: combinational, 0-cycle latency. Address 0 always returns 0.
//  - Write: at posedge when write_enable && rd != 0 && state == RUN.
//    - rd == 0: write dropped; x0 stays 0.
//    - Writes blocked in HALT_REQ and HALTED.
//  - Same-cycle read of the register being written: returns the old value
//    (unless REGFILE_BYPASS_EN).
//  - Halt FSM, 2-bit state:
//    - RUN      -> HALT_REQ when is_ecall && x17_eff == HALT_CODE; else stays RUN.
//    - HALT_REQ -> HALTED unconditionally, next cycle.
//    - HALTED   -> HALTED until reset.
//    - is_halted = (state == HALTED), registered; it is high 2 cycles after the ECALL cycle.
//    - x17_eff = array value of x17, or rd_din under bypass if rd==17 && write_enable.
//    - is_ecall with x17 != HALT_CODE: no state change; counts as retired.
//  - retire_count: +1 each posedge while state == RUN, including the halting ECALL cycle.
//    - Frozen in HALT_REQ and HALTED.
//    - Wraps modulo 2^CNT_W.
//  - Reset mid-operation, in any state: full reset values next cycle; a same-cycle write is discarded.
// CONFIGURATION
//  - REGFILE_BYPASS_EN defined:
//    - rsN_dout = rd_din when write_enable && rd == rsN && rd != 0 && state == RUN.
//    - x17_eff uses the same forwarding.
//  - REGFILE_BYPASS_EN undefined: reads return array contents only; no forwarding muxes.
// TESTING
//  - Reset -> rs1=2 gives 0x2FFF; rs1=5 gives 0; retire_count=0; is_halted=0.
//  - write_enable=1, rd=0, rd_din=0xDEADBEEF -> next cycle rs1=0 reads 0.
//  - Write rd=7, 0x1234; same cycle rs2=7 -> old value 0 (bypass off) or 0x1234 (bypass on);
//    next cycle 0x1234 in both builds.
//  - x17=10, is_ecall=1 at cycle N -> HALT_REQ at N+1, is_halted=1 at N+2;
//    write rd=5 in N+1 ignored; retire_count frozen at its value after N.
//  - x17=9, is_ecall=1 -> no halt; retire_count increments by 1.
//  - Assert reset while HALTED -> is_halted=0, regs re-initialised, counter=0 next cycle.

Source files
------------

// File: rtl/reg_file_wb.sv
// RV32I architectural register file with ECALL halt FSM and retired-instruction counter.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_wb #(
    parameter logic [31:0] STACK_INIT = 32'h0000_2FFF,
    parameter logic [31:0] HALT_CODE  = 32'd10,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    input  logic [31:0]      rd_din,
    input  logic             write_enable,
    input  logic             is_ecall,
    output logic [31:0]      rs1_dout,
    output logic [31:0]      rs2_dout,
    output logic             is_halted,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_HALT_REQ = 2'd1;
    localparam logic [1:0] ST_HALTED   = 2'd2;

    logic [31:0]      r_regs [0:31];
    logic [1:0]       r_state;
    logic             r_is_halted;
    logic [CNT_W-1:0] r_retire_count;

    logic             w_wr_ok;
    logic [31:0]      w_rs1_data;
    logic [31:0]      w_rs2_data;
    logic [31:0]      w_x17_eff;
    logic [1:0]       w_state_next;

    // Architectural writes only while running; x0 is never written.
    assign w_wr_ok = write_enable && (rd != 5'd0) && (r_state == ST_RUN);

    // Combinational read ports and effective x17 for the halt decision.
    always_comb begin
        w_rs1_data = 32'd0;
        w_rs2_data = 32'd0;
        w_x17_eff  = r_regs[17];
        if (rs1 != 5'd0) begin
            w_rs1_data = r_regs[rs1];
        end else begin
            w_rs1_data = 32'd0;
        end
        if (rs2 != 5'd0) begin
            w_rs2_data = r_regs[rs2];
        end else begin
            w_rs2_data = 32'd0;
        end
`ifdef REGFILE_BYPASS_EN
        if (w_wr_ok && (rd == rs1)) begin
            w_rs1_data = rd_din;
        end else begin
            w_rs1_data = w_rs1_data;
        end
        if (w_wr_ok && (rd == rs2)) begin
            w_rs2_data = rd_din;
        end else begin
            w_rs2_data = w_rs2_data;
        end
        if (w_wr_ok && (rd == 5'd17)) begin
            w_x17_eff = rd_din;
        end else begin
            w_x17_eff = r_regs[17];
        end
`endif
    end

    // Halt FSM next-state; an illegal encoding parks in HALTED so no writes leak out.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (is_ecall && (w_x17_eff == HALT_CODE)) begin
                    w_state_next = ST_HALT_REQ;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HALT_REQ: w_state_next = ST_HALTED;
            ST_HALTED:   w_state_next = ST_HALTED;
            default:     w_state_next = ST_HALTED;
        endcase
    end

    // Register array, FSM state, halt flag and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
            r_regs[2]      <= STACK_INIT;
            r_state        <= ST_RUN;
            r_is_halted    <= 1'b0;
            r_retire_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[rd] <= rd_din;
            end
            r_state     <= w_state_next;
            r_is_halted <= (w_state_next == ST_HALTED);
            if (r_state == ST_RUN) begin
                r_retire_count <= r_retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign rs1_dout     = w_rs1_data;
    assign rs2_dout     = w_rs2_data;
    assign is_halted    = r_is_halted;
    assign retire_count = r_retire_count;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb (reads, x0, writes, halt FSM, counter, reset).
module tb_reg_file_wb;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd_din;
    logic        write_enable;
    logic        is_ecall;
    logic [31:0] rs1_dout;
    logic [31:0] rs2_dout;
    logic        is_halted;
    logic [31:0] retire_count;

    int n_checks = 0;
    int n_errors = 0;

    reg_file_wb dut (
        .clk          (clk),
        .reset        (reset),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .rd_din       (rd_din),
        .write_enable (write_enable),
        .is_ecall     (is_ecall),
        .rs1_dout     (rs1_dout),
        .rs2_dout     (rs2_dout),
        .is_halted    (is_halted),
        .retire_count (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        write_enable = 1'b1;
        rd           = a;
        rd_din       = d;
        tick();
        write_enable = 1'b0;
    endtask

    initial begin
        logic [31:0] same_cycle_exp;
        reset = 1'b1; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; rd_din = 32'd0;
        write_enable = 1'b0; is_ecall = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        rs1 = 5'd2; rs2 = 5'd5; #1;
        check_eq("rst_sp", rs1_dout, 32'h0000_2FFF);
        check_eq("rst_x5", rs2_dout, 32'd0);
        check_eq("rst_cnt", retire_count, 32'd0);
        check_eq("rst_halt", {31'd0, is_halted}, 32'd0);

        // x0 write dropped; same-cycle read of x0 is 0 in both builds
        write_enable = 1'b1; rd = 5'd0; rd_din = 32'hDEAD_BEEF; rs1 = 5'd0; #1;
        check_eq("x0_same", rs1_dout, 32'd0);
        tick();
        write_enable = 1'b0; #1;
        check_eq("x0_next", rs1_dout, 32'd0);
        check_eq("cnt_1", retire_count, 32'd1);

        // Same-cycle read of register being written
`ifdef REGFILE_BYPASS_EN
        same_cycle_exp = 32'h0000_1234;
`else
        same_cycle_exp = 32'd0;
`endif
        write_enable = 1'b1; rd = 5'd7; rd_din = 32'h0000_1234; rs2 = 5'd7; #1;
        check_eq("x7_same", rs2_dout, same_cycle_exp);
        tick();
        write_enable = 1'b0; rs1 = 5'd7; #1;
        check_eq("x7_next_rs2", rs2_dout, 32'h0000_1234);
        check_eq("x7_next_rs1", rs1_dout, 32'h0000_1234);

        wr(5'd3, 32'hA5A5_5A5A);
        wr(5'd31, 32'hFFFF_FFFF);
        wr(5'd2, 32'h0000_0100);
        rs1 = 5'd3; rs2 = 5'd31; #1;
        check_eq("x3", rs1_dout, 32'hA5A5_5A5A);
        check_eq("x31", rs2_dout, 32'hFFFF_FFFF);
        rs1 = 5'd2; #1;
        check_eq("x2_wr", rs1_dout, 32'h0000_0100);
        check_eq("cnt_5", retire_count, 32'd5);

        // ECALL with x17 != HALT_CODE: no halt, still counts
        wr(5'd17, 32'd9);
        is_ecall = 1'b1;
        tick();
        is_ecall = 1'b0;
        check_eq("ecall9_cnt", retire_count, 32'd7);
        tick();
        check_eq("ecall9_halt", {31'd0, is_halted}, 32'd0);
        check_eq("ecall9_cnt2", retire_count, 32'd8);

        // Halting ECALL at cycle N
        wr(5'd17, 32'd10);
        is_ecall = 1'b1;
        tick();
        is_ecall = 1'b0;
        check_eq("hreq_halt", {31'd0, is_halted}, 32'd0);
        check_eq("hreq_cnt", retire_count, 32'd10);
        wr(5'd5, 32'h0000_0055);
        rs1 = 5'd5; #1;
        check_eq("halted", {31'd0, is_halted}, 32'd1);
        check_eq("hreq_wr_blk", rs1_dout, 32'd0);
        check_eq("halted_cnt", retire_count, 32'd10);
        wr(5'd6, 32'h0000_0066);
        rs2 = 5'd6; #1;
        check_eq("halted_wr_blk", rs2_dout, 32'd0);
        check_eq("halted_cnt2", retire_count, 32'd10);
        check_eq("halted_stay", {31'd0, is_halted}, 32'd1);

        // Reset while HALTED, with a same-cycle write that must be discarded
        reset = 1'b1; write_enable = 1'b1; rd = 5'd8; rd_din = 32'h0000_0077;
        tick();
        reset = 1'b0; write_enable = 1'b0;
        rs1 = 5'd2; rs2 = 5'd7; #1;
        check_eq("rst2_halt", {31'd0, is_halted}, 32'd0);
        check_eq("rst2_sp", rs1_dout, 32'h0000_2FFF);
        check_eq("rst2_x7", rs2_dout, 32'd0);
        check_eq("rst2_cnt", retire_count, 32'd0);
        rs1 = 5'd8; rs2 = 5'd17; #1;
        check_eq("rst2_x8", rs1_dout, 32'd0);
        check_eq("rst2_x17", rs2_dout, 32'd0);
        tick();
        check_eq("rst2_cnt1", retire_count, 32'd1);
        wr(5'd9, 32'h0BAD_F00D);
        rs1 = 5'd9; #1;
        check_eq("rst2_wr", rs1_dout, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
